// File: rtl/write_back_stage_param.sv
// Write-back pipeline register: selects ALU/load/link result, formats loads, suppresses x0 writes.
// Optional retired-instruction counter is built when macro RETIRE_COUNT_EN is defined.
module write_back_stage_param #(
    parameter int XLEN      = 64,
    parameter int RF_ADDR_W = 5
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_stall,
    input  logic                 i_flush,
    input  logic                 i_valid,
    input  logic [31:0]          i_instruction,
    input  logic [XLEN-1:0]      i_alu_result,
    input  logic [XLEN-1:0]      i_mem_data,
    input  logic [XLEN-1:0]      i_pc_plus4,
    input  logic                 i_reg_write,
    input  logic [1:0]           i_wb_sel,
    output logic [RF_ADDR_W-1:0] o_rd_index,
    output logic [XLEN-1:0]      o_rd_data,
    output logic                 o_rd_we,
    output logic                 o_valid
`ifdef RETIRE_COUNT_EN
    ,
    output logic [63:0]          o_retire_count
`endif
);

    logic [RF_ADDR_W-1:0] rd_index_d, rd_index_q;
    logic [XLEN-1:0]      rd_data_d,  rd_data_q;
    logic                 rd_we_d,    rd_we_q;
    logic                 valid_d,    valid_q;
    logic [RF_ADDR_W-1:0] rd;
    logic [2:0]           funct3;
    logic [XLEN-1:0]      load_val;
    logic [XLEN-1:0]      wb_val;
    logic                 capture;
    logic                 unused_instr_bits;

    assign rd       = i_instruction[RF_ADDR_W+6:7];
    assign funct3   = i_instruction[14:12];
    assign capture  = !i_flush && !i_stall;
    assign unused_instr_bits = ^{i_instruction[31:RF_ADDR_W+7], i_instruction[6:0]};

    // Size casts of $signed operands sign-extend; at XLEN=32 the word cases collapse to pass-through.
    always_comb begin
        load_val = i_mem_data;
        case (funct3)
            3'b000:  load_val = XLEN'($signed(i_mem_data[7:0]));
            3'b100:  load_val = XLEN'(i_mem_data[7:0]);
            3'b001:  load_val = XLEN'($signed(i_mem_data[15:0]));
            3'b101:  load_val = XLEN'(i_mem_data[15:0]);
            3'b010:  load_val = XLEN'($signed(i_mem_data[31:0]));
            3'b110:  load_val = XLEN'(i_mem_data[31:0]);
            default: load_val = i_mem_data;
        endcase
    end

    always_comb begin
        case (i_wb_sel)
            2'b01:   wb_val = load_val;
            2'b10:   wb_val = i_pc_plus4;
            default: wb_val = i_alu_result;
        endcase
    end

    always_comb begin
        rd_index_d = rd_index_q;
        rd_data_d  = rd_data_q;
        rd_we_d    = rd_we_q;
        valid_d    = valid_q;
        if (i_flush) begin
            // Index and data hold so forwarding sees stable values; only the live bits drop.
            valid_d = 1'b0;
            rd_we_d = 1'b0;
        end else if (!i_stall) begin
            valid_d    = i_valid;
            rd_index_d = rd;
            rd_data_d  = wb_val;
            rd_we_d    = i_valid && i_reg_write && (rd != '0);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_index_q <= '0;
            rd_data_q  <= '0;
            rd_we_q    <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            rd_index_q <= rd_index_d;
            rd_data_q  <= rd_data_d;
            rd_we_q    <= rd_we_d;
            valid_q    <= valid_d;
        end
    end

    assign o_rd_index = rd_index_q;
    assign o_rd_data  = rd_data_q;
    assign o_rd_we    = rd_we_q;
    assign o_valid    = valid_q;

`ifdef RETIRE_COUNT_EN
    logic [63:0] retire_cnt_d, retire_cnt_q;

    always_comb begin
        retire_cnt_d = retire_cnt_q;
        if (capture && i_valid)
            retire_cnt_d = retire_cnt_q + 64'd1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)
            retire_cnt_q <= '0;
        else
            retire_cnt_q <= retire_cnt_d;
    end

    assign o_retire_count = retire_cnt_q;
`else
    logic unused_capture;
    assign unused_capture = capture;
`endif

endmodule

// File: tb/tb_write_back_stage_param.sv
// Randomized + directed bench for write_back_stage_param (XLEN=64, RF_ADDR_W=5) against a reference model.
module tb_write_back_stage_param;

    logic        i_clk = 1'b0;
    logic        i_rst, i_stall, i_flush, i_valid, i_reg_write;
    logic [31:0] i_instruction;
    logic [63:0] i_alu_result, i_mem_data, i_pc_plus4;
    logic [1:0]  i_wb_sel;
    logic [4:0]  o_rd_index;
    logic [63:0] o_rd_data;
    logic        o_rd_we, o_valid;
`ifdef RETIRE_COUNT_EN
    logic [63:0] o_retire_count;
`endif

    write_back_stage_param #(.XLEN(64), .RF_ADDR_W(5)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_stall(i_stall), .i_flush(i_flush), .i_valid(i_valid),
        .i_instruction(i_instruction), .i_alu_result(i_alu_result), .i_mem_data(i_mem_data),
        .i_pc_plus4(i_pc_plus4), .i_reg_write(i_reg_write), .i_wb_sel(i_wb_sel),
        .o_rd_index(o_rd_index), .o_rd_data(o_rd_data), .o_rd_we(o_rd_we), .o_valid(o_valid)
`ifdef RETIRE_COUNT_EN
        , .o_retire_count(o_retire_count)
`endif
    );

    always #5 i_clk = ~i_clk;

    int n_chk = 0;
    int n_fail = 0;

    // Reference state
    longint unsigned m_idx, m_data, m_cnt;
    bit              m_we, m_valid;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic longint unsigned sext(longint unsigned v, int bits);
        longint unsigned half = 64'd1 << (bits - 1);
        if (v >= half) return v - (half * 2);
        return v;
    endfunction

    function automatic longint unsigned fmt(int f3, longint unsigned m);
        case (f3)
            0: return sext(m % 256, 8);
            4: return m % 256;
            1: return sext(m % 65536, 16);
            5: return m % 65536;
            2: return sext(m % (64'd1 << 32), 32);
            6: return m % (64'd1 << 32);
            default: return m;
        endcase
    endfunction

    function automatic logic [31:0] mk_instr(int rd, int f3);
        return ($urandom << 15) | (32'(f3) << 12) | (32'(rd) << 7) | ($urandom % 128);
    endfunction

    task automatic model_step();
        int rd;
        if (i_rst) begin
            m_idx = 0; m_data = 0; m_we = 0; m_valid = 0; m_cnt = 0;
        end else if (i_flush) begin
            m_valid = 0; m_we = 0;
        end else if (!i_stall) begin
            rd      = (i_instruction >> 7) % 32;
            m_valid = i_valid;
            m_idx   = rd;
            m_we    = i_valid && i_reg_write && rd != 0;
            if (i_wb_sel == 1)      m_data = fmt((i_instruction >> 12) % 8, i_mem_data);
            else if (i_wb_sel == 2) m_data = i_pc_plus4;
            else                    m_data = i_alu_result;
            if (i_valid) m_cnt = m_cnt + 1;
        end
    endtask

    // One clock: model follows the edge, outputs sampled 1 time unit later.
    task automatic cyc(input string tag);
        @(posedge i_clk);
        model_step();
        #1;
        chk({tag, ".idx"},   64'(o_rd_index), m_idx);
        chk({tag, ".data"},  o_rd_data, m_data);
        chk({tag, ".we"},    64'(o_rd_we), 64'(m_we));
        chk({tag, ".valid"}, 64'(o_valid), 64'(m_valid));
`ifdef RETIRE_COUNT_EN
        chk({tag, ".cnt"},   o_retire_count, m_cnt);
`endif
    endtask

    task automatic rand_data();
        i_instruction = $urandom;
        i_alu_result  = {$urandom, $urandom};
        i_mem_data    = {$urandom, $urandom};
        i_pc_plus4    = {$urandom, $urandom};
        i_reg_write   = 1'($urandom);
        i_valid       = 1'($urandom);
        i_wb_sel      = 2'($urandom);
    endtask

    task automatic capture_in(input int rd, input int f3, input logic [1:0] sel);
        i_rst = 0; i_stall = 0; i_flush = 0; i_valid = 1; i_reg_write = 1;
        i_instruction = mk_instr(rd, f3);
        i_wb_sel = sel;
    endtask

    localparam logic [63:0] LD_PAT = 64'h0000_0000_8000_80F0;
    localparam int          F3S[5] = '{0, 4, 1, 6, 2};
    localparam logic [63:0] FEXP[5] = '{64'hFFFF_FFFF_FFFF_FFF0, 64'h0000_0000_0000_00F0,
                                        64'hFFFF_FFFF_FFFF_80F0, 64'h0000_0000_8000_80F0,
                                        64'hFFFF_FFFF_8000_80F0};

    initial begin
        m_idx = 0; m_data = 0; m_we = 0; m_valid = 0; m_cnt = 0;
        i_stall = 0; i_flush = 0;
        rand_data();

        // Reset held two cycles with random inputs
        i_rst = 1;
        for (int k = 0; k < 2; k++) begin
            i_stall = 1'($urandom); i_flush = 1'($urandom); rand_data();
            cyc("reset");
            chk("reset.zero", {o_rd_data[62:0], o_rd_we} | 64'(o_rd_index) | 64'(o_valid), 64'd0);
        end

        // Load formatting
        for (int k = 0; k < 5; k++) begin
            capture_in(5, F3S[k], 2'b01);
            i_mem_data = LD_PAT;
            cyc("fmt");
            chk("fmt.const", o_rd_data, FEXP[k]);
        end

        // x0 suppression
        capture_in(0, 0, 2'b00);
        i_alu_result = 64'd5;
        cyc("x0");
        chk("x0.we", 64'(o_rd_we), 64'd0);
        chk("x0.data", o_rd_data, 64'd5);

        // Stall holds, then stall+flush
        capture_in(3, 0, 2'b00);
        i_alu_result = 64'h11;
        cyc("cap3");
        for (int k = 0; k < 3; k++) begin
            rand_data(); i_stall = 1;
            cyc("stall");
            chk("stall.data", o_rd_data, 64'h11);
            chk("stall.we", 64'(o_rd_we), 64'd1);
        end
        rand_data(); i_stall = 1; i_flush = 1;
        cyc("stflush");
        chk("stflush.valid", 64'(o_valid), 64'd0);
        chk("stflush.data", o_rd_data, 64'h11);

        // JAL link value and reserved select
        capture_in(1, 0, 2'b10);
        i_pc_plus4 = 64'h1004;
        cyc("jal");
        chk("jal.data", o_rd_data, 64'h1004);
        chk("jal.we", 64'(o_rd_we), 64'd1);
        capture_in(1, 0, 2'b11);
        i_alu_result = 64'hABCD;
        cyc("sel11");
        chk("sel11.data", o_rd_data, 64'hABCD);

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            rand_data();
            i_rst   = ($urandom % 32) == 0;
            i_flush = ($urandom % 8) == 0;
            i_stall = ($urandom % 5) == 0;
            cyc("rand");
        end

`ifdef RETIRE_COUNT_EN
        i_rst = 1; i_stall = 0; i_flush = 0; rand_data();
        cyc("cnt.rst");
        for (int k = 0; k < 10; k++) begin
            rand_data(); i_rst = 0; i_stall = 0; i_flush = 0; i_valid = 1;
            cyc("cnt.cap");
        end
        for (int k = 0; k < 2; k++) begin
            rand_data(); i_valid = 1; i_stall = 1;
            cyc("cnt.stall");
        end
        rand_data(); i_valid = 1; i_stall = 0; i_flush = 1;
        cyc("cnt.flush");
        chk("cnt.ten", o_retire_count, 64'd10);

        force dut.retire_cnt_q = '1;
        #1;
        release dut.retire_cnt_q;
        rand_data(); i_valid = 1; i_stall = 0; i_flush = 0;
        m_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
        cyc("cnt.wrap");
        chk("cnt.wrap0", o_retire_count, 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
